// File: rtl/line_follow_ctrl_if.sv
// Sensor/distance inputs and motor-mode outputs of the line-following steering controller.
interface line_follow_ctrl_if #(
    parameter int N_SENS = 3,
    parameter int DIST_W = 20
);
    logic              en;
    logic [N_SENS-1:0] track;
    logic [DIST_W-1:0] distance;
    logic              dist_valid;
    logic [2:0]        mode;
    logic [2:0]        state;
    logic              obstacle;

    modport master (
        output en, track, distance, dist_valid,
        input  mode, state, obstacle
    );

    modport slave (
        input  en, track, distance, dist_valid,
        output mode, state, obstacle
    );
endinterface

// File: rtl/line_follow_ctrl.sv
// Steering controller: N-way track pattern + sonic distance -> registered motor mode.
// Define LINE_FOLLOW_REVERSE_EN to add the timed reverse (BACKUP) manoeuvre out of BLOCKED.
module line_follow_ctrl #(
    parameter int N_SENS      = 3,
    parameter int DIST_W      = 20,
    parameter int STOP_DIST   = 15,
    parameter int RESUME_DIST = 25,
    parameter int SAMPLE_DIV  = 100000,
    parameter int LOST_TICKS  = 50,
    parameter int BACK_TICKS  = 20
) (
    input  logic              clk,
    input  logic              rst,
    line_follow_ctrl_if.slave io_bus
);
    localparam int C  = N_SENS / 2;
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int LW = $clog2(LOST_TICKS + 1);
    localparam int SW = $clog2(N_SENS + 1);

    localparam logic [CW-1:0]     TICK_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [LW-1:0]     LOST_LAST = LW'(LOST_TICKS - 1);
    localparam logic [DIST_W-1:0] STOP_D    = DIST_W'(STOP_DIST);
    localparam logic [DIST_W-1:0] RESUME_D  = DIST_W'(RESUME_DIST);

    localparam logic [2:0] M_STOP  = 3'd0;
    localparam logic [2:0] M_FWD   = 3'd1;
    localparam logic [2:0] M_LEFT  = 3'd2;
    localparam logic [2:0] M_RIGHT = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FOLLOW  = 3'd1,
        S_LOST    = 3'd2,
        S_BLOCKED = 3'd3,
        S_BACKUP  = 3'd4
    } state_t;

    if (N_SENS < 3 || (N_SENS % 2) == 0 || RESUME_DIST <= STOP_DIST ||
        SAMPLE_DIV < 2 || LOST_TICKS < 1 || BACK_TICKS < 1) begin : g_bad_param
        $error("line_follow_ctrl: illegal parameter set");
    end

`ifdef LINE_FOLLOW_REVERSE_EN
    localparam int             BW        = $clog2(BACK_TICKS + 1);
    localparam logic [BW-1:0]  BACK_LAST = BW'(BACK_TICKS - 1);
    localparam logic [2:0]     M_BACK    = 3'd4;
    logic [BW-1:0] r_back_cnt;
`endif

    logic [CW-1:0] r_tick_cnt;
    logic [LW-1:0] r_lost_cnt;
    logic [2:0]    r_mode;
    logic [2:0]    r_last_turn;
    logic          r_obstacle;
    logic          r_hold;
    state_t        r_state;

    logic          w_tick;
    logic [2:0]    w_steer;
    logic          w_is_turn;
    state_t        w_res_state;
    logic [2:0]    w_res_mode;

    // Outer sensors pull toward their side; a balanced or centred pattern drives straight.
    function automatic logic [2:0] steer(input logic [N_SENS-1:0] t);
        logic [SW-1:0] l;
        logic [SW-1:0] r;
        l = '0;
        r = '0;
        for (int i = C + 1; i < N_SENS; i++) if (t[i]) l = l + SW'(1);
        for (int i = 0; i < C; i++) if (t[i]) r = r + SW'(1);
        if (l > r)                     return M_LEFT;
        else if (r > l)                return M_RIGHT;
        else if (t[C] || l != '0)      return M_FWD;
        else                           return M_STOP;
    endfunction

    // Common "back on the line" outcome: follow the pattern, or go LOST if nothing is seen.
    always_comb begin
        w_tick      = (r_tick_cnt == TICK_LAST);
        w_steer     = steer(io_bus.track);
        w_is_turn   = (w_steer == M_LEFT) || (w_steer == M_RIGHT);
        w_res_state = S_FOLLOW;
        w_res_mode  = w_steer;
        if (w_steer == M_STOP) begin
            w_res_state = S_LOST;
            w_res_mode  = r_last_turn;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tick_cnt  <= '0;
            r_lost_cnt  <= '0;
            r_mode      <= M_STOP;
            r_last_turn <= M_LEFT;
            r_obstacle  <= 1'b0;
            r_hold      <= 1'b0;
            r_state     <= S_IDLE;
`ifdef LINE_FOLLOW_REVERSE_EN
            r_back_cnt  <= '0;
`endif
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);

            // A zero reading means no echo came back, so it carries no information.
            if (io_bus.dist_valid && io_bus.distance != '0) begin
                if (io_bus.distance < STOP_D)        r_obstacle <= 1'b1;
                else if (io_bus.distance >= RESUME_D) r_obstacle <= 1'b0;
            end

            if (!io_bus.en) r_hold <= 1'b0;

            if (w_tick) begin
                if (!io_bus.en) begin
                    r_state <= S_IDLE;
                    r_mode  <= M_STOP;
                end
`ifdef LINE_FOLLOW_REVERSE_EN
                else if (r_state == S_BACKUP) begin
                    if (r_back_cnt == BACK_LAST) begin
                        if (r_obstacle) begin
                            r_state <= S_BLOCKED;
                            r_mode  <= M_STOP;
                        end else begin
                            r_state    <= w_res_state;
                            r_mode     <= w_res_mode;
                            r_lost_cnt <= '0;
                            if (w_is_turn) r_last_turn <= w_steer;
                        end
                    end else begin
                        r_back_cnt <= r_back_cnt + BW'(1);
                    end
                end else if (r_state == S_BLOCKED && r_obstacle) begin
                    r_state    <= S_BACKUP;
                    r_mode     <= M_BACK;
                    r_back_cnt <= '0;
                end
`endif
                else if (r_obstacle && r_state != S_IDLE) begin
                    r_state <= S_BLOCKED;
                    r_mode  <= M_STOP;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            if (!r_hold) begin
                                r_state <= S_FOLLOW;
                                r_mode  <= M_STOP;
                            end
                        end
                        S_FOLLOW, S_BLOCKED: begin
                            r_state    <= w_res_state;
                            r_mode     <= w_res_mode;
                            r_lost_cnt <= '0;
                            if (w_is_turn) r_last_turn <= w_steer;
                        end
                        S_LOST: begin
                            if (w_steer != M_STOP) begin
                                r_state    <= S_FOLLOW;
                                r_mode     <= w_steer;
                                r_lost_cnt <= '0;
                                if (w_is_turn) r_last_turn <= w_steer;
                            end else if (r_lost_cnt == LOST_LAST) begin
                                // Give up; only an en 0->1 toggle restarts following.
                                r_state <= S_IDLE;
                                r_mode  <= M_STOP;
                                r_hold  <= 1'b1;
                            end else begin
                                r_lost_cnt <= r_lost_cnt + LW'(1);
                                r_mode     <= r_last_turn;
                            end
                        end
                        default: begin
                            r_state <= S_IDLE;
                            r_mode  <= M_STOP;
                        end
                    endcase
                end
            end
        end
    end

    assign io_bus.mode     = r_mode;
    assign io_bus.state    = r_state;
    assign io_bus.obstacle = r_obstacle;
endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl: 5 sensors, 4-cycle tick, 3-tick lost timeout.
module tb_line_follow_ctrl;
    logic clk;
    logic rst;
    int   tb_cnt;
    int   total;
    int   bad;

    line_follow_ctrl_if #(.N_SENS(5), .DIST_W(20)) bus ();

    line_follow_ctrl #(
        .N_SENS(5), .DIST_W(20), .STOP_DIST(15), .RESUME_DIST(25),
        .SAMPLE_DIV(4), .LOST_TICKS(3), .BACK_TICKS(20)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tick divider: the tick cycle is the one where tb_cnt == 3.
    always @(posedge clk) begin
        if (!rst) tb_cnt <= 0;
        else      tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Return at the negedge just after the next tick's update edge.
    task automatic next_tick();
        @(negedge clk);
        while (tb_cnt != 0) @(negedge clk);
    endtask

    // Return at the negedge inside the tick cycle (before the update edge).
    task automatic to_tick_cycle();
        @(negedge clk);
        while (tb_cnt != 3) @(negedge clk);
    endtask

    task automatic pulse(input logic [19:0] d);
        bus.distance   = d;
        bus.dist_valid = 1'b1;
        @(negedge clk);
        bus.dist_valid = 1'b0;
    endtask

    logic [4:0] pats [4];
    logic [2:0] exps [4];

    initial begin
        total = 0;
        bad   = 0;
        rst            = 1'b0;
        bus.en         = 1'b0;
        bus.track      = 5'b00000;
        bus.distance   = 20'd0;
        bus.dist_valid = 1'b0;
        pats[0] = 5'b11000; exps[0] = 3'd2;
        pats[1] = 5'b00011; exps[1] = 3'd3;
        pats[2] = 5'b01110; exps[2] = 3'd1;
        pats[3] = 5'b10001; exps[3] = 3'd1;

        // Reset, release, start-up latency
        repeat (3) @(negedge clk);
        chk("rst_mode", 32'(bus.mode), 0);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_obstacle", 32'(bus.obstacle), 0);
        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.track = 5'b00100;
        to_tick_cycle();
        chk("t1_pre_state", 32'(bus.state), 0);
        @(negedge clk);
        chk("t1_state", 32'(bus.state), 1);
        chk("t1_mode", 32'(bus.mode), 0);
        to_tick_cycle();
        chk("t1_pre_mode", 32'(bus.mode), 0);
        @(negedge clk);
        chk("t1_fwd_mode", 32'(bus.mode), 1);
        chk("t1_fwd_state", 32'(bus.state), 1);

        // Steering patterns
        for (int i = 0; i < 4; i++) begin
            bus.track = pats[i];
            next_tick();
            chk("t2_mode", 32'(bus.mode), 32'(exps[i]));
        end

        // Line loss after a right turn, timeout, en re-arm
        bus.track = 5'b00011;
        next_tick();
        chk("t3_right", 32'(bus.mode), 3);
        bus.track = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            next_tick();
            chk("t3_lost_state", 32'(bus.state), 2);
            chk("t3_lost_mode", 32'(bus.mode), 3);
        end
        next_tick();
        chk("t3_timeout_state", 32'(bus.state), 0);
        chk("t3_timeout_mode", 32'(bus.mode), 0);
        bus.track = 5'b00100;
        next_tick();
        chk("t3_hold_state", 32'(bus.state), 0);
        bus.en = 1'b0;
        next_tick();
        chk("t3_en0_state", 32'(bus.state), 0);
        bus.en = 1'b1;
        next_tick();
        chk("t3_rearm_state", 32'(bus.state), 1);
        chk("t3_rearm_mode", 32'(bus.mode), 0);
        next_tick();
        chk("t3_rearm_fwd", 32'(bus.mode), 1);

        // Obstacle hysteresis
        pulse(20'd10);
        chk("t4_obs_set", 32'(bus.obstacle), 1);
        chk("t4_state_nochg", 32'(bus.state), 1);
        next_tick();
        chk("t4_blocked_state", 32'(bus.state), 3);
        chk("t4_blocked_mode", 32'(bus.mode), 0);
        pulse(20'd20);
        chk("t4_obs_hold", 32'(bus.obstacle), 1);
        pulse(20'd0);
        chk("t4_obs_noecho", 32'(bus.obstacle), 1);
        pulse(20'd30);
        chk("t4_obs_clear", 32'(bus.obstacle), 0);
        chk("t4_pre_state", 32'(bus.state), 3);
        @(negedge clk);
        chk("t4_resume_state", 32'(bus.state), 1);
        chk("t4_resume_mode", 32'(bus.mode), 1);

        // Obstacle while LOST, then reset mid-BLOCKED
        bus.track = 5'b00000;
        next_tick();
        chk("t5_lost0", 32'(bus.state), 2);
        next_tick();
        chk("t5_lost1_state", 32'(bus.state), 2);
        chk("t5_lost1_mode", 32'(bus.mode), 3);
        pulse(20'd5);
        chk("t5_obs", 32'(bus.obstacle), 1);
        next_tick();
        chk("t5_blocked_state", 32'(bus.state), 3);
        chk("t5_blocked_mode", 32'(bus.mode), 0);
        @(negedge clk);
        rst = 1'b0;
        pulse(20'd5);
        chk("t5_rst_state", 32'(bus.state), 0);
        chk("t5_rst_mode", 32'(bus.mode), 0);
        chk("t5_rst_obs", 32'(bus.obstacle), 0);

        // Obstacle held: reverse manoeuvre or indefinite wait
        rst       = 1'b1;
        bus.track = 5'b00100;
        next_tick();
        chk("t6_follow", 32'(bus.state), 1);
        next_tick();
        chk("t6_fwd", 32'(bus.mode), 1);
        pulse(20'd10);
        chk("t6_obs", 32'(bus.obstacle), 1);
        next_tick();
        chk("t6_blocked", 32'(bus.state), 3);
`ifdef LINE_FOLLOW_REVERSE_EN
        for (int i = 0; i < 20; i++) begin
            next_tick();
            chk("t6_back_state", 32'(bus.state), 4);
            chk("t6_back_mode", 32'(bus.mode), 4);
        end
        next_tick();
        chk("t6_reblocked_state", 32'(bus.state), 3);
        chk("t6_reblocked_mode", 32'(bus.mode), 0);
        next_tick();
        chk("t6_back2_state", 32'(bus.state), 4);
        bus.en = 1'b0;
        next_tick();
        chk("t6_abort_state", 32'(bus.state), 0);
        chk("t6_abort_mode", 32'(bus.mode), 0);
`else
        for (int i = 0; i < 21; i++) begin
            next_tick();
            chk("t6_wait_state", 32'(bus.state), 3);
            chk("t6_wait_mode", 32'(bus.mode), 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
